// File: rtl/sevenseg_pkg.sv
// Shared types for the 7-segment display path.
// Digit codes and scanner phase states.
package sevenseg_pkg;
    localparam int DIGIT_W = 4;
    typedef logic [DIGIT_W-1:0] digit_t;
    typedef enum logic {GAP, SHOW} scan_state_e;
endpackage

// File: rtl/scan_timer.sv
// Phase counter for the digit scanner: alternates dark GAP and lit SHOW.
// Emits one-cycle pulses on the last cycle of each phase.
module scan_timer #(
    parameter int DIV = 50000,
    parameter int GAP = 2
) (
    input  logic clk,
    input  logic n_reset,
    output logic show_start,
    output logic show_end
);
    import sevenseg_pkg::*;

    localparam int MAXC = (DIV > GAP) ? DIV : GAP;
    localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] GAP_T = CW'(GAP - 1);
    localparam logic [CW-1:0] DIV_T = CW'(DIV - 1);

    scan_state_e state;
    logic [CW-1:0] cnt;

    assign show_start = (state == sevenseg_pkg::GAP) && (cnt == GAP_T);
    assign show_end = (state == sevenseg_pkg::SHOW) && (cnt == DIV_T);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= sevenseg_pkg::GAP;
            cnt <= '0;
        end else if (show_start) begin
            state <= sevenseg_pkg::SHOW;
            cnt <= '0;
        end else if (show_end) begin
            state <= sevenseg_pkg::GAP;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/digit_scan.sv
// Time-multiplexed digit scanner; new values commit only at frame wrap.
// Define DIGIT_SCAN_LZB_EN for leading-zero blanking.
module digit_scan #(
    parameter int NDIGITS = 4,
    parameter int DIV = 50000,
    parameter int GAP = 2
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic [4*NDIGITS-1:0] value_i,
    input  logic                 load_valid,
    output logic                 load_ready,
    output logic [3:0]           address,
    output logic [NDIGITS-1:0]   digit_en
);
    import sevenseg_pkg::*;

    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int VW = DIGIT_W * NDIGITS;
    localparam logic [IW-1:0] LAST = IW'(NDIGITS - 1);

    logic [VW-1:0] disp;
    logic [VW-1:0] pend;
    logic          pend_full;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_nxt;
    logic          show_start;
    logic          show_end;
    logic          wrap;
    logic          load_fire;
    logic          lit;

    function automatic digit_t digit_of(input logic [VW-1:0] v,
                                        input logic [IW-1:0] k);
        return v[DIGIT_W*k +: DIGIT_W];
    endfunction

    scan_timer #(
        .DIV(DIV),
        .GAP(GAP)
    ) u_timer (
        .clk       (clk),
        .n_reset   (n_reset),
        .show_start(show_start),
        .show_end  (show_end)
    );

    assign load_ready = !pend_full;
    assign load_fire = load_valid && load_ready;
    assign wrap = show_end && (idx == LAST);
    assign idx_nxt = wrap ? '0 : idx + 1'b1;

`ifdef DIGIT_SCAN_LZB_EN
    // Dark if this and every more significant digit is zero.
    always_comb begin
        lit = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (IW'(i) >= idx && disp[DIGIT_W*i +: DIGIT_W] != '0)
                lit = 1'b1;
        end
        if (idx == '0)
            lit = 1'b1;
    end
`else
    assign lit = 1'b1;
`endif

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            disp <= '0;
            pend <= '0;
            pend_full <= 1'b0;
            idx <= '0;
            address <= '0;
            digit_en <= '0;
        end else begin
            if (load_fire) begin
                pend <= value_i;
                pend_full <= 1'b1;
            end
            if (show_start)
                digit_en <= lit ? (NDIGITS'(1) << idx) : '0;
            if (show_end) begin
                digit_en <= '0;
                idx <= idx_nxt;
                // Commit and load never coincide: ready is low while full.
                if (wrap && pend_full) begin
                    disp <= pend;
                    pend_full <= 1'b0;
                    address <= pend[DIGIT_W-1:0];
                end else begin
                    address <= digit_of(disp, idx_nxt);
                end
            end
        end
    end
endmodule

// File: tb/tb_digit_scan.sv
// Directed bench for digit_scan: NDIGITS=4, DIV=4, GAP=1.
// Slot table drives loads and checks each gap/show slot.
module tb_digit_scan;
`ifdef DIGIT_SCAN_LZB_EN
    localparam logic LZB = 1'b1;
`else
    localparam logic LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic [15:0] value_i = '0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [3:0]  address;
    logic [3:0]  digit_en;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        pre_v;
        logic [15:0] pre_d;
        logic        mid_v;
        logic [15:0] mid_d;
        logic        end_v;
        logic [15:0] end_d;
        logic [3:0]  addr;
        logic [3:0]  en;
        logic        rdy;
    } slot_t;

    slot_t tbl[24];

    digit_scan #(
        .NDIGITS(4),
        .DIV(4),
        .GAP(1)
    ) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .value_i   (value_i),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .address   (address),
        .digit_en  (digit_en)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] lz(input logic [3:0] e);
        return LZB ? 4'b0000 : e;
    endfunction

    task automatic chk(input string nm, input int s,
                       input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s slot %0d: got %h want %h", nm, s, act, exp);
        end
    endtask

    task automatic run_slot(input int s, input slot_t t);
        load_valid = t.pre_v;
        value_i = t.pre_d;
        chk("gap_en", s, 16'(digit_en), 16'h0);
        chk("gap_addr", s, 16'(address), 16'(t.addr));
        @(posedge clk); #1;
        chk("lit_en", s, 16'(digit_en), 16'(t.en));
        chk("lit_addr", s, 16'(address), 16'(t.addr));
        load_valid = t.mid_v;
        value_i = t.mid_d;
        repeat (3) begin
            @(posedge clk); #1;
            chk("lit_en", s, 16'(digit_en), 16'(t.en));
            chk("lit_addr", s, 16'(address), 16'(t.addr));
        end
        load_valid = t.end_v;
        value_i = t.end_d;
        @(posedge clk); #1;
        chk("end_en", s, 16'(digit_en), 16'h0);
        chk("end_rdy", s, 16'(load_ready), 16'(t.rdy));
    endtask

    initial begin
        // Frame A: disp 0, load 4321 at first show edge
        tbl[0]  = '{1, 16'h4321, 0, 0, 0, 0, 4'h0, 4'b0001, 0};
        tbl[1]  = '{0, 0, 0, 0, 0, 0, 4'h0, lz(4'b0010), 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 4'h0, lz(4'b0100), 0};
        tbl[3]  = '{0, 0, 0, 0, 0, 0, 4'h0, lz(4'b1000), 1};
        // Frame B: 4321; ABCD mid-frame, then held 1111/2222 ignored
        tbl[4]  = '{0, 0, 0, 0, 0, 0, 4'h1, 4'b0001, 1};
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 4'h2, 4'b0010, 1};
        tbl[6]  = '{1, 16'hABCD, 1, 16'h1111, 1, 16'h1111,
                    4'h3, 4'b0100, 0};
        tbl[7]  = '{1, 16'h1111, 1, 16'h2222, 1, 16'h1111,
                    4'h4, 4'b1000, 1};
        // Frame C: ABCD; 0005 handshakes on the wrap edge
        tbl[8]  = '{0, 0, 0, 0, 0, 0, 4'hD, 4'b0001, 1};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 4'hC, 4'b0010, 1};
        tbl[10] = '{0, 0, 0, 0, 0, 0, 4'hB, 4'b0100, 1};
        tbl[11] = '{0, 0, 0, 0, 1, 16'h0005, 4'hA, 4'b1000, 0};
        // Frame D: still ABCD, 0005 commits at its wrap
        tbl[12] = '{0, 0, 0, 0, 0, 0, 4'hD, 4'b0001, 0};
        tbl[13] = '{0, 0, 0, 0, 0, 0, 4'hC, 4'b0010, 0};
        tbl[14] = '{0, 0, 0, 0, 0, 0, 4'hB, 4'b0100, 0};
        tbl[15] = '{0, 0, 0, 0, 0, 0, 4'hA, 4'b1000, 1};
        // Frame E: 0005; load 0050
        tbl[16] = '{1, 16'h0050, 0, 0, 0, 0, 4'h5, 4'b0001, 0};
        tbl[17] = '{0, 0, 0, 0, 0, 0, 4'h0, lz(4'b0010), 0};
        tbl[18] = '{0, 0, 0, 0, 0, 0, 4'h0, lz(4'b0100), 0};
        tbl[19] = '{0, 0, 0, 0, 0, 0, 4'h0, lz(4'b1000), 1};
        // Frame F: 0050
        tbl[20] = '{0, 0, 0, 0, 0, 0, 4'h0, 4'b0001, 1};
        tbl[21] = '{0, 0, 0, 0, 0, 0, 4'h5, 4'b0010, 1};
        tbl[22] = '{0, 0, 0, 0, 0, 0, 4'h0, lz(4'b0100), 1};
        tbl[23] = '{0, 0, 0, 0, 0, 0, 4'h0, lz(4'b1000), 1};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_en", -1, 16'(digit_en), 16'h0);
        chk("rst_addr", -1, 16'(address), 16'h0);
        chk("rst_rdy", -1, 16'(load_ready), 16'h1);
        n_reset = 1'b1;

        for (int i = 0; i < 24; i++)
            run_slot(i, tbl[i]);

        // Reset mid-SHOW with a pending value that must be discarded
        load_valid = 1'b1;
        value_i = 16'h9999;
        @(posedge clk); #1;
        load_valid = 1'b0;
        chk("pre_en", 100, 16'(digit_en), 16'h1);
        repeat (6) @(posedge clk);
        #1;
        chk("pre_en", 101, 16'(digit_en), 16'h2);
        chk("pre_addr", 101, 16'(address), 16'h5);
        chk("pre_rdy", 101, 16'(load_ready), 16'h0);
        n_reset = 1'b0;
        #1;
        chk("mid_rst_en", 102, 16'(digit_en), 16'h0);
        chk("mid_rst_addr", 102, 16'(address), 16'h0);
        chk("mid_rst_rdy", 102, 16'(load_ready), 16'h1);
        @(posedge clk); #1;
        n_reset = 1'b1;
        chk("rel_en", 103, 16'(digit_en), 16'h0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("rel_lit", 104 + k, 16'(digit_en), 16'h1);
            chk("rel_addr", 104 + k, 16'(address), 16'h0);
        end
        @(posedge clk); #1;
        chk("rel_gap", 108, 16'(digit_en), 16'h0);
        repeat (15) @(posedge clk);
        #1;
        chk("discard_addr", 109, 16'(address), 16'h0);
        chk("discard_rdy", 109, 16'(load_ready), 16'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
